multiplier_control: RTL and testbench
=====================================

Name: multiplier_control

Overview:
- Sequencing FSM for the 8-bit signed shift-add multiplier datapath. It sits directly upstream of the A/X/B registers and the 9-bit add/sub unit.
- On each run request it clears A/X, then performs WIDTH add-then-shift iterations. Each iteration is conditioned on the multiplier LSB M. The final iteration subtracts, giving two's-complement correction.
- It then holds a done indication until run is released, so one button press yields exactly one multiply.

Parameters:
- WIDTH, 8, operand width and number of add/shift iterations (must be >= 2)
- CW, $clog2(WIDTH), width of the iteration counter (derived, not overridden)

Ports:
- Clk  input  1  system clock, rising-edge
- Reset  input  1  asynchronous, active-high reset
- run_i  input  1  synchronized, debounced run level (high = pressed)
- m_i  input  1  current multiplier LSB (B register bit 0)
- clear_a_o  output  1  synchronous clear strobe for the A and X registers
- load_a_o  output  1  load A and X from the adder sum
- shift_o  output  1  arithmetic right shift of X:A:B
- fn_o  output  1  adder function: 0 = add, 1 = subtract
- busy_o  output  1  high from the CLEAR state through the last SHIFT state
- done_o  output  1  high while in the DONE state
- iter_o  output  CW  current iteration index, 0..WIDTH-1

Behaviour:
- Reset is asynchronous and active-high. On assertion the FSM goes to IDLE and the counter goes to 0. All outputs are 0 during and after reset.
- Reset mid-operation aborts immediately; no further load or shift strobes are issued.
- States are IDLE, CLEAR, ADD, SHIFT, DONE. The state register and counter update on the rising edge of Clk.
- IDLE: all strobes 0. If run_i = 1, go to CLEAR; otherwise stay.
- CLEAR (one cycle): clear_a_o = 1, busy_o = 1, counter cleared to 0. Go to ADD.
- ADD (one cycle):
  - load_a_o = m_i.
  - fn_o = 1 if counter == WIDTH-1, else 0. fn_o is driven by the counter regardless of m_i.
  - shift_o = 0. Go to SHIFT.
- SHIFT (one cycle):
  - shift_o = 1, load_a_o = 0, fn_o = 0.
  - If counter == WIDTH-1, go to DONE.
  - Otherwise increment the counter and go to ADD.
- DONE: done_o = 1, busy_o = 0, all strobes 0. If run_i = 0, go to IDLE; otherwise stay. Holding run_i never starts a second multiply.
- Strobe exclusivity: load_a_o, shift_o and clear_a_o are never high in the same cycle.
- Output decoding:
  - load_a_o is the only output combinationally dependent on m_i (Mealy).
  - All other outputs decode from state and counter only.
- iter_o equals the counter value. It is 0 in IDLE, CLEAR and DONE.
- Timing, with run_i sampled high in IDLE at edge k:
  - clear_a_o is high in cycle k+1.
  - The first ADD is cycle k+2.
  - The last SHIFT is cycle k+2*WIDTH+1.
  - done_o rises in cycle k+2*WIDTH+2 (k+18 for WIDTH = 8).
- run_i dropping mid-operation has no effect; the multiply completes.
- Illegal state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: MULT_CTRL_AUTO_CLEAR_EN.
- Defined: the CLEAR state exists exactly as described above.
- Undefined:
  - CLEAR is removed and clear_a_o is tied to 0.
  - IDLE with run_i = 1 goes directly to ADD with the counter at 0, and busy_o rises at that ADD.
  - Existing A/X contents are accumulated, supporting chained multiplies.
  - done_o rises at k+2*WIDTH+1 (k+17 for WIDTH = 8).

Test Plan:
- Reset values: assert Reset for 3 cycles with run_i = 1, then release → all outputs 0, FSM in IDLE. Because run_i is still high, CLEAR follows on the next edge.
- All ones multiplier: WIDTH = 8, m_i held 1, run pulse → clear_a_o for 1 cycle, load_a_o high in all 8 ADD cycles, fn_o high only on the 8th ADD, 8 shift_o pulses, done_o at k+18.
- All zeros multiplier: m_i held 0 → load_a_o never high, still exactly 8 shift_o pulses, fn_o high in 8th ADD only, done_o at k+18.
- Run held: run_i held high for 100 cycles → exactly one operation, done_o stays high until run_i falls, then IDLE. A second press starts a fresh sequence with iter_o = 0.
- Reset mid-operation: assert Reset asynchronously (between edges) during SHIFT with iter_o = 3 → all outputs 0 before the next edge. After release with run_i = 0, the FSM stays in IDLE.
- Macro undefined: run pulse → no clear_a_o, first ADD at k+1, done_o at k+17, 8 shift_o pulses.

Source files
------------

// File: rtl/multiplier_control.sv
// Sequencing FSM for the signed shift-add multiplier: clear, WIDTH add/shift steps, then done.
// Define MULT_CTRL_AUTO_CLEAR_EN to clear A/X before each multiply; otherwise A/X accumulate.
module multiplier_control #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = $clog2(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          run_i,
    input  logic          m_i,
    output logic          clear_a_o,
    output logic          load_a_o,
    output logic          shift_o,
    output logic          fn_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] iter_o
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAdd,
        StShift,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_iter;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign iter_o    = cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clear_a_o = 1'b0;
        load_a_o  = 1'b0;
        shift_o   = 1'b0;
        fn_o      = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (run_i) begin
`ifdef MULT_CTRL_AUTO_CLEAR_EN
                    state_d = StClear;
`else
                    state_d = StAdd;
`endif
                end
            end
`ifdef MULT_CTRL_AUTO_CLEAR_EN
            StClear: begin
                clear_a_o = 1'b1;
                busy_o    = 1'b1;
                cnt_d     = '0;
                state_d   = StAdd;
            end
`endif
            StAdd: begin
                busy_o   = 1'b1;
                load_a_o = m_i;
                // Last partial product has negative weight: subtract it.
                fn_o     = last_iter;
                state_d  = StShift;
            end
            StShift: begin
                busy_o  = 1'b1;
                shift_o = 1'b1;
                if (last_iter) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = StAdd;
                end
            end
            StDone: begin
                done_o = 1'b1;
                cnt_d  = '0;
                if (!run_i) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench for multiplier_control: reset, bit patterns, held run, mid-operation reset.
module tb_multiplier_control;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH);
`ifdef MULT_CTRL_AUTO_CLEAR_EN
    localparam int DONE_CYC = 2 * WIDTH + 2;
    localparam int EXP_CLR  = 1;
`else
    localparam int DONE_CYC = 2 * WIDTH + 1;
    localparam int EXP_CLR  = 0;
`endif

    logic          Clk = 1'b0;
    logic          Reset;
    logic          run_i;
    logic          m_i;
    logic          clear_a_o, load_a_o, shift_o, fn_o, busy_o, done_o;
    logic [CW-1:0] iter_o;

    int total = 0;
    int bad   = 0;

    multiplier_control #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .run_i    (run_i),
        .m_i      (m_i),
        .clear_a_o(clear_a_o),
        .load_a_o (load_a_o),
        .shift_o  (shift_o),
        .fn_o     (fn_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .iter_o   (iter_o)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({clear_a_o, load_a_o, shift_o, fn_o, busy_o, done_o, iter_o});
    endfunction

    // Runs one multiply starting from IDLE; m_i follows pat, one bit per ADD.
    task automatic run_op(input string name, input logic [7:0] pat, input bit hold,
                          input int ncyc);
        int n_clear = 0, n_load = 0, n_shift = 0, n_add = 0, n_fn = 0, fn_at = 0;
        int n_done = 0, first_done = 0, excl = 0, load_err = 0, iter_err = 0, fn_stray = 0;
        bit is_add;
        run_i = 1'b1;
        m_i   = pat[0];
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge Clk);
            #1;
            if (i == 1 && !hold) run_i = 1'b0;
            is_add = busy_o && !shift_o && !clear_a_o;
            if (int'(clear_a_o) + int'(load_a_o) + int'(shift_o) > 1) excl++;
            if (clear_a_o) n_clear++;
            if (load_a_o) n_load++;
            if (is_add) begin
                if (n_add < WIDTH && load_a_o !== pat[n_add]) load_err++;
                if (int'(iter_o) != n_add) iter_err++;
                if (fn_o) begin
                    n_fn++;
                    fn_at = n_add + 1;
                end
                n_add++;
            end else if (fn_o) begin
                fn_stray++;
            end
            if (shift_o) n_shift++;
            if (!busy_o && iter_o != '0) iter_err++;
            if (done_o) begin
                n_done++;
                if (first_done == 0) first_done = i;
            end
            if (n_add < WIDTH) m_i = pat[n_add];
        end
        check({name, ".clear"}, n_clear, EXP_CLR);
        check({name, ".loads"}, n_load, $countones(pat));
        check({name, ".load_bits"}, load_err, 0);
        check({name, ".adds"}, n_add, WIDTH);
        check({name, ".shifts"}, n_shift, WIDTH);
        check({name, ".fn_count"}, n_fn + fn_stray, 1);
        check({name, ".fn_at"}, fn_at, WIDTH);
        check({name, ".done_cycle"}, first_done, DONE_CYC);
        check({name, ".done_len"}, n_done, hold ? ncyc - DONE_CYC + 1 : 1);
        check({name, ".exclusive"}, excl, 0);
        check({name, ".iter"}, iter_err, 0);
    endtask

    initial begin
        bit found;
        Reset = 1'b1;
        run_i = 1'b1;
        m_i   = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset.during", all_outs(), 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("reset.after", all_outs(), 0);
        @(posedge Clk);
        #1;
        check("reset.first_clear", int'(clear_a_o), EXP_CLR);
        check("reset.first_busy", int'(busy_o), 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge Clk);
            #1;
            if (done_o) found = 1'b1;
        end
        check("reset.op_done", int'(found), 1);
        run_i = 1'b0;
        @(posedge Clk);
        #1;
        check("reset.back_idle", int'({busy_o, done_o}), 0);

        run_op("ones", 8'hFF, 1'b0, 22);
        run_op("zeros", 8'h00, 1'b0, 22);
        run_op("a5", 8'hA5, 1'b0, 22);
        run_op("hold", 8'h3C, 1'b1, 100);
        run_i = 1'b0;
        @(posedge Clk);
        #1;
        check("hold.release", int'({busy_o, done_o}), 0);
        run_op("again", 8'h5A, 1'b0, 22);

        // Abort between edges while in the SHIFT of iteration 3.
        run_i = 1'b1;
        m_i   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge Clk);
            #1;
            if (shift_o && iter_o == CW'(3)) found = 1'b1;
        end
        check("midreset.reached", int'(found), 1);
        #2;
        Reset = 1'b1;
        #1;
        check("midreset.outs", all_outs(), 0);
        run_i = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("midreset.idle", all_outs(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
